// File: rtl/kl8e_tty_if.sv
// IOT bus and UART byte-channel bundle for the KL8E console teletype controller.
// Handshakes: iotStb qualifies inst/acIn for exactly one SYSCLK and acOut/acClr/skip answer in that
// same cycle; txStb/rxAck are one-cycle pulses, txRdy/rxRdy are levels and only the rxRdy rising edge counts.
interface kl8e_tty_if;
  logic        iotStb;
  logic [11:0] inst;
  logic [11:0] acIn;
  logic [11:0] acOut;
  logic        acClr;
  logic        skip;
  logic        irq;
  logic [7:0]  txData;
  logic        txStb;
  logic        txRdy;
  logic [7:0]  rxData;
  logic        rxRdy;
  logic        rxAck;

  modport slave (
    input  iotStb, inst, acIn, txRdy, rxData, rxRdy,
    output acOut, acClr, skip, irq, txData, txStb, rxAck
  );

  modport master (
    output iotStb, inst, acIn, txRdy, rxData, rxRdy,
    input  acOut, acClr, skip, irq, txData, txStb, rxAck
  );
endinterface

// File: rtl/kl8e_tty.sv
// PDP-8 KL8E console teletype controller: keyboard (device 03) and printer (device 04) on the IOT bus.
// Optional build macro KL8E_MARKPARITY_EN forces bit 7 high on received bytes and low on transmitted bytes.
module kl8e_tty #(
  parameter logic [5:0] KBD_DEV = 6'o03,
  parameter logic [5:0] PRT_DEV = 6'o04
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  kl8e_tty_if.slave  bus,
  output logic [1:0] prtStateDbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITRDY = 2'd1,
    STROBE  = 2'd2,
    BUSY    = 2'd3
  } prtState_t;

  prtState_t   prtState;
  logic        kbdFlag;
  logic        prtFlag;
  logic        ie;
  logic [7:0]  kbdBuf;
  logic        rxRdyQ;
  logic        sawLow;
  logic        irqQ;
  logic        rxAckQ;
  logic [7:0]  txDataQ;
  logic        txStbQ;

  // Instruction decode
  logic       isIot;
  logic       kbdSel;
  logic       prtSel;
  logic [2:0] fn;

  assign isIot  = bus.iotStb && (bus.inst[11:9] == 3'b110);
  assign kbdSel = isIot && (bus.inst[8:3] == KBD_DEV);
  assign prtSel = isIot && (bus.inst[8:3] == PRT_DEV);
  assign fn     = bus.inst[2:0];

  logic kcfOp, ksfOp, kccOp, krsOp, kieOp, krbOp;
  logic spfOp, tsfOp, tcfOp, tpcOp, spiOp, tlsOp;

  assign kcfOp = kbdSel && (fn == 3'd0);
  assign ksfOp = kbdSel && (fn == 3'd1);
  assign kccOp = kbdSel && (fn == 3'd2);
  assign krsOp = kbdSel && (fn == 3'd4);
  assign kieOp = kbdSel && (fn == 3'd5);
  assign krbOp = kbdSel && (fn == 3'd6);

  assign spfOp = prtSel && (fn == 3'd0);
  assign tsfOp = prtSel && (fn == 3'd1);
  assign tcfOp = prtSel && (fn == 3'd2);
  assign tpcOp = prtSel && (fn == 3'd4);
  assign spiOp = prtSel && (fn == 3'd5);
  assign tlsOp = prtSel && (fn == 3'd6);

  logic kbdClr;
  logic prtStart;
  logic prtClr;
  logic rxEdge;
  logic prtDone;

  assign kbdClr   = kcfOp || kccOp || krbOp;
  assign prtStart = tpcOp || tlsOp;
  assign prtClr   = tcfOp || tlsOp;
  assign rxEdge   = bus.rxRdy && !rxRdyQ;
  assign prtDone  = (prtState == BUSY) && sawLow && bus.txRdy;

  // Byte-format adaptation at the UART boundary
  logic [7:0] rxCapture;
  logic [7:0] txLoad;

`ifdef KL8E_MARKPARITY_EN
  assign rxCapture = {1'b1, bus.rxData[6:0]};
  assign txLoad    = {1'b0, bus.acIn[6:0]};
`else
  assign rxCapture = bus.rxData;
  assign txLoad    = bus.acIn[7:0];
`endif

  // Strobe-cycle responses to the CPU
  always_comb begin
    bus.acOut = 12'o0000;
    bus.acClr = kccOp || krbOp;
    bus.skip  = (ksfOp && kbdFlag) ||
                (tsfOp && prtFlag) ||
                (spiOp && ie && (kbdFlag || prtFlag));
    if (krsOp || krbOp) begin
      bus.acOut = {4'b0000, kbdBuf};
    end
  end

  // Keyboard side, interrupt enable and the registered interrupt request
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      rxRdyQ  <= 1'b0;
      kbdFlag <= 1'b0;
      kbdBuf  <= 8'h00;
      rxAckQ  <= 1'b0;
      ie      <= 1'b1;
      irqQ    <= 1'b0;
    end else begin
      rxRdyQ <= bus.rxRdy;
      rxAckQ <= rxEdge;
      // A capture beats a same-cycle clear so a fresh byte is never lost
      if (rxEdge) begin
        kbdBuf  <= rxCapture;
        kbdFlag <= 1'b1;
      end else if (kbdClr) begin
        kbdFlag <= 1'b0;
      end
      if (kieOp) begin
        ie <= bus.acIn[0];
      end
      irqQ <= ie && (kbdFlag || prtFlag);
    end
  end

  // Printer FSM with registered UART outputs and the printer flag
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      prtState <= IDLE;
      txDataQ  <= 8'h00;
      txStbQ   <= 1'b0;
      sawLow   <= 1'b0;
      prtFlag  <= 1'b0;
    end else begin
      txStbQ <= 1'b0;
      case (prtState)
        IDLE: begin
          if (prtStart) begin
            txDataQ  <= txLoad;
            prtState <= WAITRDY;
          end
        end
        WAITRDY: begin
          if (bus.txRdy) begin
            txStbQ   <= 1'b1;
            prtState <= STROBE;
          end
        end
        STROBE: begin
          sawLow   <= 1'b0;
          prtState <= BUSY;
        end
        BUSY: begin
          // Completion needs the UART to drop ready and raise it again
          if (!bus.txRdy) begin
            sawLow <= 1'b1;
          end else if (sawLow) begin
            prtState <= IDLE;
          end
        end
        default: prtState <= IDLE;
      endcase
      if (prtDone || spfOp) begin
        prtFlag <= 1'b1;
      end else if (prtClr) begin
        prtFlag <= 1'b0;
      end
    end
  end

  assign bus.irq     = irqQ;
  assign bus.rxAck   = rxAckQ;
  assign bus.txData  = txDataQ;
  assign bus.txStb   = txStbQ;
  assign prtStateDbg = prtState;

endmodule

// File: tb/tb_kl8e_tty.sv
// Bench for kl8e_tty: IOT vector table from reset, then receive, print, collision and reset-mid-print sequences.
module tb_kl8e_tty;

  logic       SYSCLK;
  logic       RESET;
  logic [1:0] prtStateDbg;

  kl8e_tty_if bus();

  kl8e_tty dut (
    .SYSCLK      (SYSCLK),
    .RESET       (RESET),
    .bus         (bus),
    .prtStateDbg (prtStateDbg)
  );

`ifdef KL8E_MARKPARITY_EN
  localparam logic [11:0] KRB41 = 12'o0301;
  localparam logic [11:0] KRB42 = 12'o0302;
  localparam logic [7:0]  TX215 = 8'h0D;
`else
  localparam logic [11:0] KRB41 = 12'o0101;
  localparam logic [11:0] KRB42 = 12'o0102;
  localparam logic [7:0]  TX215 = 8'h8D;
`endif

  // Clock / reset
  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] expQ[$];

  typedef struct {
    logic        stb;
    logic [11:0] inst;
    logic [11:0] ac;
    logic        expSkip;
    logic        expClr;
    logic [11:0] expOut;
    logic        expIrq;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  // Driver: one IOT strobe cycle, responses checked mid-cycle
  task automatic iot(input logic [11:0] ins, input logic [11:0] ac, input logic expSkip,
                     input logic expClr, input logic [11:0] expOut, input string name);
    bus.iotStb = 1'b1;
    bus.inst   = ins;
    bus.acIn   = ac;
    @(negedge SYSCLK);
    check({name, " skip"},  bus.skip,  expSkip);
    check({name, " acClr"}, bus.acClr, expClr);
    check({name, " acOut"}, bus.acOut, expOut);
    @(posedge SYSCLK);
    #1;
    bus.iotStb = 1'b0;
    bus.inst   = 12'o0000;
    bus.acIn   = 12'o0000;
  endtask

  task automatic rxByte(input logic [7:0] b);
    bus.rxData = b;
    bus.rxRdy  = 1'b1;
    step(1);
    check("rxAck pulse", bus.rxAck, 1'b1);
    step(1);
    check("rxAck one cycle", bus.rxAck, 1'b0);
    bus.rxRdy = 1'b0;
  endtask

  task automatic waitTxStb(input string name);
    int n;
    n = 0;
    while (!bus.txStb && n < 20) begin
      step(1);
      n++;
    end
    check({name, " txStb seen"}, bus.txStb, 1'b1);
    step(1);
    check({name, " txStb one cycle"}, bus.txStb, 1'b0);
  endtask

  // Scoreboard: every UART load must match the next expected byte
  always @(negedge SYSCLK) begin
    if (bus.txStb) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected txStb: txData %0h with nothing expected", bus.txData);
      end else begin
        check("txData at strobe", bus.txData, expQ.pop_front());
      end
    end
  end

  initial begin
    RESET      = 1'b1;
    bus.iotStb = 1'b0;
    bus.inst   = 12'o0000;
    bus.acIn   = 12'o0000;
    bus.txRdy  = 1'b1;
    bus.rxData = 8'h00;
    bus.rxRdy  = 1'b0;

    vecs[0]  = '{1'b1, 12'o6031, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[1]  = '{1'b1, 12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[2]  = '{1'b1, 12'o6045, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[3]  = '{1'b1, 12'o6040, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[4]  = '{1'b1, 12'o6041, 12'o0000, 1'b1, 1'b0, 12'o0000, 1'b0};
    vecs[5]  = '{1'b0, 12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[6]  = '{1'b1, 12'o6051, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[7]  = '{1'b1, 12'o7041, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[8]  = '{1'b1, 12'o6045, 12'o0000, 1'b1, 1'b0, 12'o0000, 1'b1};
    vecs[9]  = '{1'b1, 12'o6043, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[10] = '{1'b1, 12'o6042, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[11] = '{1'b1, 12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b1};
    vecs[12] = '{1'b1, 12'o6034, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[13] = '{1'b1, 12'o6032, 12'o7777, 1'b0, 1'b1, 12'o0000, 1'b0};
    vecs[14] = '{1'b1, 12'o6036, 12'o0000, 1'b0, 1'b1, 12'o0000, 1'b0};
    vecs[15] = '{1'b1, 12'o6035, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[16] = '{1'b1, 12'o6040, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[17] = '{1'b1, 12'o6045, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[18] = '{1'b1, 12'o6042, 12'o0000, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[19] = '{1'b1, 12'o6035, 12'o0001, 1'b0, 1'b0, 12'o0000, 1'b0};
    vecs[20] = '{1'b1, 12'o6037, 12'o7777, 1'b0, 1'b0, 12'o0000, 1'b0};

    step(2);
    RESET = 1'b0;
    step(2);
    check("reset irq",      bus.irq,     1'b0);
    check("reset txStb",    bus.txStb,   1'b0);
    check("reset rxAck",    bus.rxAck,   1'b0);
    check("reset txData",   bus.txData,  8'h00);
    check("reset prtState", prtStateDbg, 2'd0);
    check("reset acOut",    bus.acOut,   12'o0000);

    // Back-to-back IOT vectors, one per cycle; irq reflects state two vectors back
    for (int i = 0; i < 21; i++) begin
      bus.iotStb = vecs[i].stb;
      bus.inst   = vecs[i].inst;
      bus.acIn   = vecs[i].ac;
      @(negedge SYSCLK);
      check($sformatf("vec%0d skip", i),  bus.skip,  vecs[i].expSkip);
      check($sformatf("vec%0d acClr", i), bus.acClr, vecs[i].expClr);
      check($sformatf("vec%0d acOut", i), bus.acOut, vecs[i].expOut);
      check($sformatf("vec%0d irq", i),   bus.irq,   vecs[i].expIrq);
      @(posedge SYSCLK);
      #1;
    end
    bus.iotStb = 1'b0;
    bus.inst   = 12'o0000;
    bus.acIn   = 12'o0000;
    step(2);

    // Receive 'A', read it back with KRB
    bus.rxData = 8'h41;
    bus.rxRdy  = 1'b1;
    step(1);
    check("rx41 rxAck", bus.rxAck, 1'b1);
    check("rx41 irq lag", bus.irq, 1'b0);
    step(1);
    check("rx41 rxAck drop", bus.rxAck, 1'b0);
    check("rx41 irq", bus.irq, 1'b1);
    bus.rxRdy = 1'b0;
    iot(12'o6031, 12'o0000, 1'b1, 1'b0, 12'o0000, "KSF after rx");
    iot(12'o6045, 12'o0000, 1'b1, 1'b0, 12'o0000, "SPI after rx");
    iot(12'o6036, 12'o0000, 1'b0, 1'b1, KRB41, "KRB 41");
    iot(12'o6031, 12'o0000, 1'b0, 1'b0, 12'o0000, "KSF after KRB");
    check("irq after KRB", bus.irq, 1'b0);

    // KCF drops the interrupt
    rxByte(8'h55);
    check("irq rx55", bus.irq, 1'b1);
    iot(12'o6030, 12'o0000, 1'b0, 1'b0, 12'o0000, "KCF");
    step(1);
    check("irq after KCF", bus.irq, 1'b0);

    // Receive edge in the same cycle as KCF, then an overrun byte
    bus.rxData = 8'h33;
    bus.rxRdy  = 1'b1;
    iot(12'o6030, 12'o0000, 1'b0, 1'b0, 12'o0000, "KCF with rx edge");
    iot(12'o6031, 12'o0000, 1'b1, 1'b0, 12'o0000, "KSF after collision");
    bus.rxRdy = 1'b0;
    step(1);
    rxByte(8'h42);
    iot(12'o6036, 12'o0000, 1'b0, 1'b1, KRB42, "KRB overrun");
    iot(12'o6031, 12'o0000, 1'b0, 1'b0, 12'o0000, "KSF after overrun KRB");

    // TLS with txRdy high; completion needs txRdy low then high
    expQ.push_back(TX215);
    iot(12'o6046, 12'o0215, 1'b0, 1'b0, 12'o0000, "TLS");
    waitTxStb("TLS");
    iot(12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, "TSF busy");
    bus.txRdy = 1'b0;
    step(2);
    iot(12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, "TSF txRdy low");
    bus.txRdy = 1'b1;
    step(1);
    iot(12'o6041, 12'o0000, 1'b1, 1'b0, 12'o0000, "TSF done");
    check("irq prtFlag", bus.irq, 1'b1);
    check("FSM idle after print", prtStateDbg, 2'd0);
    iot(12'o6042, 12'o0000, 1'b0, 1'b0, 12'o0000, "TCF");
    step(1);
    check("irq after TCF", bus.irq, 1'b0);

    // Start while busy is ignored; completion colliding with TCF leaves flag set
    bus.txRdy = 1'b0;
    expQ.push_back(8'h41);
    iot(12'o6044, 12'o0101, 1'b0, 1'b0, 12'o0000, "TPC 41");
    check("FSM waitrdy", prtStateDbg, 2'd1);
    iot(12'o6044, 12'o0102, 1'b0, 1'b0, 12'o0000, "TPC ignored");
    check("txData kept", bus.txData, 8'h41);
    bus.txRdy = 1'b1;
    waitTxStb("TPC 41");
    bus.txRdy = 1'b0;
    step(2);
    bus.txRdy = 1'b1;
    iot(12'o6042, 12'o0000, 1'b0, 1'b0, 12'o0000, "TCF with completion");
    iot(12'o6041, 12'o0000, 1'b1, 1'b0, 12'o0000, "TSF after collision");
    iot(12'o6042, 12'o0000, 1'b0, 1'b0, 12'o0000, "TCF clear");
    iot(12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, "TSF cleared");

    // Reset while BUSY, then a normal print
    expQ.push_back(8'h54);
    iot(12'o6044, 12'o0124, 1'b0, 1'b0, 12'o0000, "TPC 54");
    waitTxStb("TPC 54");
    check("FSM busy", prtStateDbg, 2'd3);
    RESET = 1'b1;
    #2;
    check("reset mid FSM", prtStateDbg, 2'd0);
    check("reset mid txStb", bus.txStb, 1'b0);
    RESET = 1'b0;
    step(1);
    iot(12'o6041, 12'o0000, 1'b0, 1'b0, 12'o0000, "TSF after reset");
    expQ.push_back(8'h53);
    iot(12'o6044, 12'o0123, 1'b0, 1'b0, 12'o0000, "TPC 53");
    waitTxStb("TPC 53");
    bus.txRdy = 1'b0;
    step(2);
    bus.txRdy = 1'b1;
    step(1);
    iot(12'o6041, 12'o0000, 1'b1, 1'b0, 12'o0000, "TSF after reprint");

    step(2);
    check("expected bytes drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
